// File: rtl/fp32_add_seq.sv
// fp32_add_seq: multi-cycle FP32 adder/subtractor.
// One operation in flight. Exponents are compared and the operands swapped
// on accept. The small mantissa is then aligned one bit per cycle, the
// mantissas are added or subtracted, and the sum is normalised one step per
// cycle. Every step truncates; there are no guard, round or sticky bits.
// Denormal inputs are flushed to zero. Exponent-255 inputs are not handled.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready.
// The producer holds its payload stable while valid is high and ready is low.
// in_ready is high only in IDLE, so the cycle that leaves DONE cannot also
// accept. out_valid is high only in DONE. result holds its value until the
// consumer takes it.
module fp32_add_seq #(
  parameter int MAX_ALIGN = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  stateDbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] MaxAlignW = 8'(MAX_ALIGN);

  state_t      state;
  state_t      nextState;

  logic [7:0]  bigExp;
  logic [23:0] bigMan;
  logic [23:0] smallMan;
  logic        bigSign;
  logic        smallSign;
  logic [7:0]  diff;
  logic [24:0] sum;
  logic [7:0]  normExp;
  logic [31:0] resultReg;

  // Operand decode and ordering, evaluated on the incoming pair.
  logic [7:0]  aExp;
  logic [7:0]  bExp;
  logic [23:0] aMan;
  logic [23:0] bMan;
  logic        aIsBig;
  logic [7:0]  inBigExp;
  logic [7:0]  inSmallExp;
  logic [23:0] inBigMan;
  logic [23:0] inSmallMan;
  logic        inBigSign;
  logic        inSmallSign;
  logic [7:0]  inDiff;
  logic        clampAlign;

  // Normalisation helpers.
  logic [7:0]  expInc;
  logic [7:0]  expDec;
  logic [24:0] sumShr;
  logic [24:0] sumShl;

  // Decode the operands and pick the big one. Ties on exponent go to the
  // larger mantissa, and a full tie goes to A.
  always_comb begin
    aExp        = a[30:23];
    bExp        = b[30:23];
    aMan        = (aExp == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    bMan        = (bExp == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    aIsBig      = (aExp > bExp) || ((aExp == bExp) && (aMan >= bMan));
    inBigExp    = aIsBig ? aExp  : bExp;
    inSmallExp  = aIsBig ? bExp  : aExp;
    inBigMan    = aIsBig ? aMan  : bMan;
    inSmallMan  = aIsBig ? bMan  : aMan;
    inBigSign   = aIsBig ? a[31] : b[31];
    inSmallSign = aIsBig ? b[31] : a[31];
    inDiff      = inBigExp - inSmallExp;
    clampAlign  = (inDiff >= MaxAlignW);
  end

  // Shifted and stepped values that one normalisation step can choose from.
  always_comb begin
    expInc = normExp + 8'd1;
    expDec = normExp - 8'd1;
    sumShr = sum >> 1;
    sumShl = sum << 1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic and the handshake outputs.
  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    stateDbg  = state;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nextState = ALIGN;
      end
      ALIGN: begin
        if (diff == 8'd0) nextState = ADD;
      end
      ADD: begin
        nextState = NORM;
      end
      NORM: begin
        if ((sum == 25'd0) || sum[24] || sum[23]) begin
          nextState = DONE;
        end else if (expDec == 8'd0) begin
          nextState = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath registers: capture, alignment, add/sub, normalise and pack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bigExp    <= 8'd0;
      bigMan    <= 24'd0;
      smallMan  <= 24'd0;
      bigSign   <= 1'b0;
      smallSign <= 1'b0;
      diff      <= 8'd0;
      sum       <= 25'd0;
      normExp   <= 8'd0;
      resultReg <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bigExp    <= inBigExp;
            bigMan    <= inBigMan;
            bigSign   <= inBigSign;
            smallSign <= inSmallSign;
            if (clampAlign) begin
              // Far too small to survive truncation: drop it outright.
              smallMan <= 24'd0;
              diff     <= 8'd0;
            end else begin
              smallMan <= inSmallMan;
              diff     <= inDiff;
            end
          end
        end
        ALIGN: begin
          if (diff != 8'd0) begin
            smallMan <= smallMan >> 1;
            diff     <= diff - 8'd1;
          end
        end
        ADD: begin
          // Big magnitude >= small magnitude, so the difference is never negative.
          if (bigSign == smallSign) begin
            sum <= {1'b0, bigMan} + {1'b0, smallMan};
          end else begin
            sum <= {1'b0, bigMan} - {1'b0, smallMan};
          end
          normExp <= bigExp;
        end
        NORM: begin
          if (sum == 25'd0) begin
            resultReg <= 32'd0;
          end else if (sum[24]) begin
            sum     <= sumShr;
            normExp <= expInc;
            if (expInc == 8'hFF) begin
              resultReg <= {bigSign, 8'hFF, 23'd0};
            end else begin
              resultReg <= {bigSign, expInc, sumShr[22:0]};
            end
          end else if (sum[23]) begin
            resultReg <= {bigSign, normExp, sum[22:0]};
          end else begin
            sum     <= sumShl;
            normExp <= expDec;
            if (expDec == 8'd0) resultReg <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = resultReg;

endmodule

// File: tb/tb_fp32_add_seq.sv
// Bench for fp32_add_seq: directed cases, reset abort, backpressure, and
// random back-to-back traffic checked against a truncating reference model.
module tb_fp32_add_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [2:0]  stateDbg;

  int npass = 0;
  int ntotal = 0;
  logic [31:0] exp_q[$];

  fp32_add_seq #(.MAX_ALIGN(26)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .stateDbg(stateDbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Reference model from the arithmetic rules. It returns the packed result
  // and the accept-to-valid latency in clocks, counting the accept edge as 1.
  function automatic void ref_add(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output int lat);
    int ex, ey, mx, my, eb, es, mb, ms, d, s, e, nl;
    bit sb, ss;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex == 0) ? 0 : (1 << 23) + int'(x[22:0]);
    my = (ey == 0) ? 0 : (1 << 23) + int'(y[22:0]);
    if (ex > ey || (ex == ey && mx >= my)) begin
      eb = ex; mb = mx; sb = x[31]; es = ey; ms = my; ss = y[31];
    end else begin
      eb = ey; mb = my; sb = y[31]; es = ex; ms = mx; ss = x[31];
    end
    d = eb - es;
    if (d >= 26) begin
      ms = 0;
      d = 0;
    end else begin
      ms = ms >> d;
    end
    s = (sb == ss) ? mb + ms : mb - ms;
    e = eb;
    nl = 0;
    if (s == 0) begin
      r = 32'd0;
      lat = 4 + d;
    end else if (s >= (1 << 24)) begin
      s = s / 2;
      e = e + 1;
      r = (e == 255) ? {sb, 8'hFF, 23'd0} : {sb, 8'(e), 23'(s)};
      lat = 4 + d;
    end else begin
      while (s < (1 << 23)) begin
        s = s * 2;
        e = e - 1;
        nl = nl + 1;
        if (e == 0) break;
      end
      if (e == 0) begin
        r = 32'd0;
        lat = 3 + d + nl;
      end else begin
        r = {sb, 8'(e), 23'(s)};
        lat = 4 + d + nl;
      end
    end
  endfunction

  // Driver: present one pair, wait for out_valid, and consume it if out_ready.
  // lat is -1 when out_valid never arrives within the budget.
  task automatic run_op(input logic [31:0] opA, input logic [31:0] opB,
                        output logic [31:0] res, output int lat);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b1;
    a = opA;
    b = opB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    res = result;
    if (out_ready && out_valid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ntotal++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
    else npass++;
    ntotal++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid);
    else npass++;
    ntotal++;
    if (result !== 32'd0) $display("FAIL reset_result got=%h want=00000000", result);
    else npass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    int spurious;
    in_valid = 1'b1;
    a = 32'h3F800000;
    b = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    ntotal++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midreset_outputs got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else npass++;
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) spurious++;
    end
    ntotal++;
    if (spurious != 0) $display("FAIL midreset_spurious got=%0d valid cycles want=0", spurious);
    else npass++;
  endtask

  task automatic test_basic_add;
    logic [31:0] ta[2], tb2[2], res;
    int lat;
    ta[0] = 32'h3F800000; tb2[0] = 32'h40000000;
    ta[1] = 32'h40000000; tb2[1] = 32'h3F800000;
    for (int i = 0; i < 2; i++) begin
      run_op(ta[i], tb2[i], res, lat);
      ntotal++;
      if (res !== 32'h40400000) $display("FAIL add_result[%0d] got=%h want=40400000", i, res);
      else npass++;
      ntotal++;
      if (lat != 5) $display("FAIL add_latency[%0d] got=%0d want=5", i, lat);
      else npass++;
    end
  endtask

  task automatic test_cancel;
    logic [31:0] ta[2], tb2[2], er[2], res;
    int el[2];
    int lat;
    ta[0] = 32'h3FC00000; tb2[0] = 32'hBF800000; er[0] = 32'h3F000000; el[0] = 5;
    ta[1] = 32'h3F800000; tb2[1] = 32'hBF800000; er[1] = 32'h00000000; el[1] = 4;
    for (int i = 0; i < 2; i++) begin
      run_op(ta[i], tb2[i], res, lat);
      ntotal++;
      if (res !== er[i]) $display("FAIL cancel_result[%0d] got=%h want=%h", i, res, er[i]);
      else npass++;
      ntotal++;
      if (lat != el[i]) $display("FAIL cancel_latency[%0d] got=%0d want=%0d", i, lat, el[i]);
      else npass++;
    end
  endtask

  task automatic test_align_edges;
    logic [31:0] ta[3], tb2[3], er[3], res;
    int el[3];
    int lat;
    ta[0] = 32'h3F800000; tb2[0] = 32'h33800000; er[0] = 32'h3F800000; el[0] = 28;
    ta[1] = 32'h3F800000; tb2[1] = 32'h00000000; er[1] = 32'h3F800000; el[1] = 4;
    ta[2] = 32'h7F7FFFFF; tb2[2] = 32'h7F7FFFFF; er[2] = 32'h7F800000; el[2] = 4;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb2[i], res, lat);
      ntotal++;
      if (res !== er[i]) $display("FAIL edge_result[%0d] got=%h want=%h", i, res, er[i]);
      else npass++;
      ntotal++;
      if (lat != el[i]) $display("FAIL edge_latency[%0d] got=%0d want=%0d", i, lat, el[i]);
      else npass++;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] res, held;
    int lat, unstable, readyHigh, validLow;
    out_ready = 1'b0;
    run_op(32'h3F800000, 32'h40000000, res, lat);
    ntotal++;
    if (res !== 32'h40400000 || lat != 5)
      $display("FAIL bp_first got=%h lat=%0d want=40400000 lat=5", res, lat);
    else npass++;
    held = result;
    unstable = 0; readyHigh = 0; validLow = 0;
    in_valid = 1'b1;
    a = 32'h40800000;
    b = 32'h40800000;
    repeat (10) begin
      @(posedge clk); #1;
      if (result !== 32'h40400000) unstable++;
      if (in_ready !== 1'b0) readyHigh++;
      if (out_valid !== 1'b1) validLow++;
    end
    ntotal++;
    if (unstable != 0) $display("FAIL bp_stable got=%0d changed cycles want=0", unstable);
    else npass++;
    ntotal++;
    if (readyHigh != 0) $display("FAIL bp_in_ready got=%0d high cycles want=0", readyHigh);
    else npass++;
    ntotal++;
    if (validLow != 0) $display("FAIL bp_out_valid got=%0d low cycles want=0", validLow);
    else npass++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    ntotal++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else npass++;
    in_valid = 1'b0;
    @(posedge clk); #1;
    ntotal++;
    if (out_valid !== 1'b0 || held !== 32'h40400000)
      $display("FAIL bp_no_accept got out_valid=%b held=%h want 0/40400000", out_valid, held);
    else npass++;
  endtask

  task automatic run_random(input bit mixedSigns, input string tag);
    logic [31:0] opA, opB, er, res;
    logic [7:0] ea, eb;
    int el, lat, eaI, ebI;
    bit sa, sb;
    for (int i = 0; i < 20; i++) begin
      eaI = $urandom_range(40, 200);
      ebI = eaI + $urandom_range(0, 60) - 30;
      ea = 8'(eaI);
      eb = 8'(ebI);
      sa = 1'($urandom_range(0, 1));
      sb = mixedSigns ? 1'($urandom_range(0, 1)) : sa;
      opA = {sa, ea, 23'($urandom)};
      opB = {sb, eb, 23'($urandom)};
      ref_add(opA, opB, er, el);
      exp_q.push_back(er);
      run_op(opA, opB, res, lat);
      er = exp_q.pop_front();
      ntotal++;
      if (res !== er)
        $display("FAIL %s_result[%0d] a=%h b=%h got=%h want=%h", tag, i, opA, opB, res, er);
      else npass++;
      ntotal++;
      if (lat != el)
        $display("FAIL %s_latency[%0d] a=%h b=%h got=%0d want=%0d", tag, i, opA, opB, lat, el);
      else npass++;
      ntotal++;
      if (in_ready !== 1'b1) $display("FAIL %s_ready_after[%0d] got=%b want=1", tag, i, in_ready);
      else npass++;
    end
  endtask

  task automatic test_back_to_back;
    run_random(1'b0, "b2b");
  endtask

  task automatic test_mixed_signs;
    run_random(1'b1, "mixed");
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_basic_add();
    test_cancel();
    test_align_edges();
    test_backpressure();
    test_back_to_back();
    test_mixed_signs();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
